// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
//  Module      : mc_ctrl_pkg
//  Description : Shared types and encodings for the multicycle MIPS controller.
//                Optional BNEEX state is gated by MC_CONTROLLER_BNE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
`ifdef MC_CONTROLLER_BNE_EN
        JEX     = 4'd11,
        BNEEX   = 4'd12
`else
        JEX     = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // fetch marks strobes that must be qualified by mem_ready
    typedef struct packed {
        logic       fetch;
        logic       pcwrite;
        logic       branch;
        logic       branch_ne;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       alusrca;
        logic       regdst;
        logic       memtoreg;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_outdec.sv
// ============================================================================
//  Module      : mc_ctrl_outdec
//  Description : Combinational state-to-control-word decode (Moore outputs).
//                BNEEX decode present only with MC_CONTROLLER_BNE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t i_state,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            FETCH: begin
                o_ctrl.fetch   = 1'b1;
                o_ctrl.irwrite = 1'b1;
                o_ctrl.pcwrite = 1'b1;
                o_ctrl.alusrcb = SRCB_FOUR;
                o_ctrl.aluop   = ALUOP_ADD;
                o_ctrl.pcsrc   = PCSRC_ALU;
            end
            DECODE: begin
                o_ctrl.alusrcb = SRCB_IMMSH;
                o_ctrl.aluop   = ALUOP_ADD;
            end
            MEMADR, ADDIEX: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = SRCB_IMM;
            end
            MEMRD: o_ctrl.iord = 1'b1;
            MEMWB: begin
                o_ctrl.memtoreg = 1'b1;
                o_ctrl.regwrite = 1'b1;
            end
            MEMWR: begin
                o_ctrl.iord     = 1'b1;
                o_ctrl.memwrite = 1'b1;
            end
            RTYPEEX: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = SRCB_RD2;
                o_ctrl.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                o_ctrl.regdst   = 1'b1;
                o_ctrl.regwrite = 1'b1;
            end
            BEQEX: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.aluop   = ALUOP_SUB;
                o_ctrl.pcsrc   = PCSRC_ALUOUT;
                o_ctrl.branch  = 1'b1;
            end
`ifdef MC_CONTROLLER_BNE_EN
            BNEEX: begin
                o_ctrl.alusrca   = 1'b1;
                o_ctrl.aluop     = ALUOP_SUB;
                o_ctrl.pcsrc     = PCSRC_ALUOUT;
                o_ctrl.branch    = 1'b1;
                o_ctrl.branch_ne = 1'b1;
            end
`endif
            ADDIWB: o_ctrl.regwrite = 1'b1;
            JEX: begin
                o_ctrl.pcsrc   = PCSRC_JUMP;
                o_ctrl.pcwrite = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// ============================================================================
//  Module      : mc_controller
//  Description : Multicycle MIPS main controller: state register, next-state
//                logic and mem_ready/zero gating. MC_CONTROLLER_BNE_EN adds bne.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int BITLENGTH = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       alusrca,
    output logic       regdst,
    output logic       memtoreg,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    logic   w_illegal;
    logic   w_pcwrite;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= FETCH;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next    = FETCH;
        w_illegal = 1'b0;
        case (r_state)
            FETCH:   w_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = RTYPEEX;
                    OP_BEQ:       w_next = BEQEX;
                    OP_ADDI:      w_next = ADDIEX;
                    OP_J:         w_next = JEX;
`ifdef MC_CONTROLLER_BNE_EN
                    OP_BNE:       w_next = BNEEX;
`endif
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = FETCH;
                    end
                endcase
            end
            MEMADR:  w_next = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   w_next = mem_ready ? MEMWB : MEMRD;
            MEMWR:   w_next = mem_ready ? FETCH : MEMWR;
            RTYPEEX: w_next = RTYPEWB;
            ADDIEX:  w_next = ADDIWB;
            default: w_next = FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    // Fetch strobes wait on memory; branch polarity flips for bne
    always_comb begin
        w_pcwrite  = w_ctrl.pcwrite & (mem_ready | ~w_ctrl.fetch);
        pcen       = w_pcwrite | (w_ctrl.branch & (zero ^ w_ctrl.branch_ne));
        irwrite    = w_ctrl.irwrite & mem_ready;
        memwrite   = w_ctrl.memwrite;
        regwrite   = w_ctrl.regwrite;
        iord       = w_ctrl.iord;
        alusrca    = w_ctrl.alusrca;
        regdst     = w_ctrl.regdst;
        memtoreg   = w_ctrl.memtoreg;
        alusrcb    = w_ctrl.alusrcb;
        pcsrc      = w_ctrl.pcsrc;
        aluop      = w_ctrl.aluop;
        illegal_op = w_illegal;
        state_o    = r_state;
    end

endmodule

`default_nettype wire
